decode_wide: RTL

Parametrised N-lane RISC-V decode stage between the fetch instruction buffer and rename. It decodes WIDTH instructions per cycle into instruction_t bundles with a per-lane valid mask, and flags illegal encodings per lane. A two-entry output/skid register gives a full valid/ready handshake: decode_rdy is registered and has no combinational path from rename_rdy, at full one-bundle-per-cycle throughput.

---
 rtl/decode_wide_pkg.sv | 68 ++++++
 rtl/decode_wide_lane.sv | 85 ++++++++
 rtl/decode_wide.sv | 107 ++++++++++
 3 files changed

// File: rtl/decode_wide_pkg.sv
// Shared ISA and micro-architecture definitions for the wide decode stage.
// Provides the base opcodes, funct3/funct7 constants, the immediate-format
// enum, the decoded instruction bundle type and the pipeline width.
package decode_wide_pkg;

  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_INST_BITS = 32;
  localparam int CPU_DATA_BITS = 32;
  localparam int REG_BITS      = 5;
  localparam int PIPE_WIDTH    = 2;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_ITYPE  = 7'b0010011,
    OP_RTYPE  = 7'b0110011,
    OP_CSR    = 7'b1110011
  } opcode_e;

  localparam logic [2:0] FNC_ADD_SUB = 3'b000;
  localparam logic [2:0] FNC_SLL     = 3'b001;
  localparam logic [2:0] FNC_SR      = 3'b101;

  localparam logic [6:0] FNC7_NORMAL = 7'b0000000;
  localparam logic [6:0] FNC7_ALT    = 7'b0100000;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;

  // An operand is either a register tag or a literal; the unused half is 0.
  typedef struct packed {
    logic [REG_BITS-1:0]      tag;
    logic [CPU_DATA_BITS-1:0] data;
  } operand_t;

  typedef struct packed {
    logic [CPU_ADDR_BITS-1:0] pc;
    logic [6:0]               opcode;
    logic [REG_BITS-1:0]      rd;
    logic [6:0]               funct7;
    operand_t                 src_0_a;
    operand_t                 src_0_b;
    operand_t                 src_1_a;
    operand_t                 src_1_b;
    logic [CPU_DATA_BITS-1:0] imm;
    logic [2:0]               uop_0;
    logic [2:0]               uop_1;
    logic                     br_taken;
    logic                     has_rd;
    logic                     is_valid;
  } instruction_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
    case (op)
      OP_ITYPE, OP_LOAD, OP_JALR: imm_fmt = IMM_I;
      OP_STORE:                   imm_fmt = IMM_S;
      OP_BRANCH:                  imm_fmt = IMM_B;
      OP_LUI, OP_AUIPC:           imm_fmt = IMM_U;
      OP_JAL:                     imm_fmt = IMM_J;
      default:                    imm_fmt = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_wide_lane.sv
// Single-lane combinational decoder.
// Ports: lane_val (lane carries an instruction), pc, inst (raw word)
//        -> dec (instruction_t bundle), illegal (valid but unsupported).
module decode_lane
  import decode_wide_pkg::*;
(
  input  logic                     lane_val,
  input  logic [CPU_ADDR_BITS-1:0] pc,
  input  logic [CPU_INST_BITS-1:0] inst,
  output instruction_t             dec,
  output logic                     illegal
);

  logic [6:0]               op;
  logic [2:0]               f3;
  logic [6:0]               f7;
  logic [REG_BITS-1:0]      rd, rs1, rs2;
  logic [CPU_DATA_BITS-1:0] imm;
  logic                     legal;

  assign op  = inst[6:0];
  assign rd  = inst[11:7];
  assign f3  = inst[14:12];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];
  assign f7  = inst[31:25];

  always_comb begin
    case (imm_fmt(op))
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'h000};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  always_comb begin
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_CSR: legal = 1'b1;
      // ALT is only meaningful for SUB and SRA.
      OP_RTYPE: legal = (f7 == FNC7_NORMAL) ||
                        ((f7 == FNC7_ALT) && ((f3 == FNC_ADD_SUB) || (f3 == FNC_SR)));
      // Shift-immediates reuse the upper imm bits as funct7.
      OP_ITYPE: begin
        if (f3 == FNC_SLL)     legal = (f7 == FNC7_NORMAL);
        else if (f3 == FNC_SR) legal = (f7 == FNC7_NORMAL) || (f7 == FNC7_ALT);
        else                   legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec             = '0;
    dec.pc          = pc;
    dec.opcode      = op;
    dec.rd          = rd;
    dec.funct7      = f7;
    dec.imm         = imm;
    dec.src_1_a.tag = rs1;
    dec.src_1_b.tag = rs2;
    if ((op == OP_AUIPC) || (op == OP_JAL) || (op == OP_BRANCH)) dec.src_0_a.data = pc;
    else                                                         dec.src_0_a.tag  = rs1;
    if (op == OP_RTYPE) dec.src_0_b.tag  = rs2;
    else                dec.src_0_b.data = imm;
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE: dec.uop_0 = f3;
      default:                               dec.uop_0 = FNC_ADD_SUB;
    endcase
    dec.uop_1    = (op == OP_BRANCH) ? f3 : 3'b000;
    dec.br_taken = (op == OP_JAL) || (op == OP_JALR);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_ITYPE, OP_RTYPE:
        dec.has_rd = (rd != '0);
      default: dec.has_rd = 1'b0;
    endcase
    dec.is_valid = lane_val & legal;
  end

  assign illegal = lane_val & ~legal;

endmodule

// File: rtl/decode_wide.sv
// WIDTH-lane decode stage with output register and optional skid entry.
// Ports: clk, rst (sync, active-high), flush; fetch_val/lane_val/inst_pcs/
//        insts/decode_rdy from fetch; decode_val/decoded_insts/illegal/
//        rename_rdy toward rename.
// With SKID_EN the skid entry absorbs the bundle accepted in the cycle
// rename stalls, so decode_rdy can be a flop with no path from rename_rdy.
module decode_wide
  import decode_wide_pkg::*;
#(
  parameter int WIDTH   = PIPE_WIDTH,
  parameter bit SKID_EN = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                fetch_val,
  input  logic [WIDTH-1:0]                    lane_val,
  input  logic [WIDTH-1:0][CPU_ADDR_BITS-1:0] inst_pcs,
  input  logic [WIDTH-1:0][CPU_INST_BITS-1:0] insts,
  output logic                                decode_rdy,
  input  logic                                rename_rdy,
  output logic                                decode_val,
  output instruction_t [WIDTH-1:0]            decoded_insts,
  output logic [WIDTH-1:0]                    illegal
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

  state_e                   state, state_n;
  instruction_t [WIDTH-1:0] dec, out_q, skid_q;
  logic [WIDTH-1:0]         dec_ill, out_ill_q, skid_ill_q;
  logic                     rdy_q;
  logic                     accept, drain;
  logic                     load_out, load_skid, skid_to_out;

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    decode_lane u_lane (
      .lane_val (lane_val[l]),
      .pc       (inst_pcs[l]),
      .inst     (insts[l]),
      .dec      (dec[l]),
      .illegal  (dec_ill[l])
    );
  end

  assign decode_val = (state != ST_EMPTY);
  assign decode_rdy = SKID_EN ? rdy_q : (~decode_val | rename_rdy);
  assign accept     = fetch_val & decode_rdy;
  assign drain      = decode_val & rename_rdy;

  always_comb begin
    state_n     = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      ST_EMPTY: if (accept) begin
        state_n  = ST_FULL;
        load_out = 1'b1;
      end
      ST_FULL: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_n   = ST_SKID;
          load_skid = 1'b1;
        end else if (drain) begin
          state_n = ST_EMPTY;
        end
      end
      ST_SKID: if (drain) begin
        state_n     = ST_FULL;
        skid_to_out = 1'b1;
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= ST_EMPTY;
      rdy_q      <= 1'b1;
      out_q      <= '0;
      out_ill_q  <= '0;
      skid_q     <= '0;
      skid_ill_q <= '0;
    end else begin
      state <= state_n;
      rdy_q <= (state_n != ST_SKID);
      if (load_out) begin
        out_q     <= dec;
        out_ill_q <= dec_ill;
      end else if (skid_to_out) begin
        out_q     <= skid_q;
        out_ill_q <= skid_ill_q;
      end
      if (load_skid) begin
        skid_q     <= dec;
        skid_ill_q <= dec_ill;
      end
    end
  end

  assign decoded_insts = out_q;
  assign illegal       = out_ill_q;

endmodule
